// File: rtl/memory_arbiter.sv
// ============================================================================
// Module      : memory_arbiter
// Description : Single-port RAM arbiter between an instruction and a data
//               requester, with bounded starvation of the instruction side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  localparam int          c_CW     = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [c_CW-1:0] c_MAX = c_CW'(STARVE_MAX);
  localparam logic [1:0]  c_ACCESS = 2'd2;
  localparam logic [1:0]  c_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_ren, r_wen, w_ren_nxt, w_wen_nxt;
  logic [31:0]       r_addr, r_store, w_addr_nxt, w_store_nxt;
  logic [c_CW-1:0]   r_starve_cnt, w_starve_cnt_nxt;
  logic              w_dreq, w_ram_done, w_i_done, w_d_done;

  assign w_dreq     = dREN | dWEN;
  assign w_ram_done = (ramstate == c_ACCESS) || (ramstate == c_ERROR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_ren        <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_store      <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ren        <= w_ren_nxt;
      r_wen        <= w_wen_nxt;
      r_addr       <= w_addr_nxt;
      r_store      <= w_store_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ren_nxt   = r_ren;
    w_wen_nxt   = r_wen;
    w_addr_nxt  = r_addr;
    w_store_nxt = r_store;
    w_i_done    = 1'b0;
    w_d_done    = 1'b0;
    merr        = 1'b0;
    iload       = '0;
    dload       = '0;

    // Under reset the grant states are treated as IDLE so nothing completes.
    if (!RST) begin
      case (r_state)
        IDLE: begin
          if (iREN && (!w_dreq || r_starve_cnt == c_MAX)) begin
            w_state_nxt = GNT_I;
            w_ren_nxt   = 1'b1;
            w_wen_nxt   = 1'b0;
            w_addr_nxt  = iaddr;
          end else if (w_dreq) begin
            w_state_nxt = GNT_D;
            w_ren_nxt   = ~dWEN;
            w_wen_nxt   = dWEN;
            w_addr_nxt  = daddr;
            w_store_nxt = dstore;
          end
        end
        GNT_I: begin
          if (!iREN) begin
            w_state_nxt = IDLE;
            w_ren_nxt   = 1'b0;
            w_wen_nxt   = 1'b0;
          end else if (w_ram_done) begin
            w_i_done    = 1'b1;
            iload       = ramload;
            merr        = (ramstate == c_ERROR);
            w_state_nxt = IDLE;
            w_ren_nxt   = 1'b0;
            w_wen_nxt   = 1'b0;
          end
        end
        GNT_D: begin
          if (!w_dreq) begin
            w_state_nxt = IDLE;
            w_ren_nxt   = 1'b0;
            w_wen_nxt   = 1'b0;
          end else if (w_ram_done) begin
            w_d_done    = 1'b1;
            dload       = ramload;
            merr        = (ramstate == c_ERROR);
            w_state_nxt = IDLE;
            w_ren_nxt   = 1'b0;
            w_wen_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_ren_nxt   = 1'b0;
          w_wen_nxt   = 1'b0;
        end
      endcase
    end

    w_starve_cnt_nxt = r_starve_cnt;
    if (!iREN || w_i_done)
      w_starve_cnt_nxt = '0;
    else if (w_d_done && r_starve_cnt != c_MAX)
      w_starve_cnt_nxt = r_starve_cnt + c_CW'(1);
  end

  assign iwait    = iREN & ~w_i_done;
  assign dwait    = w_dreq & ~w_d_done;
  assign ramREN   = r_ren;
  assign ramWEN   = r_wen;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Directed vector table plus starvation sequence for memory_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, merr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, iren;
    logic [31:0] iaddr;
    logic        dren, dwen;
    logic [31:0] daddr, dstore;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        e_iwait, e_dwait;
    logic [31:0] e_iload, e_dload;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        e_merr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, iren, input logic [31:0] ia,
                     input logic dr, dw, input logic [31:0] da, ds,
                     input logic [1:0] rs, input logic [31:0] rl,
                     input logic eiw, edw, input logic [31:0] eil, edl,
                     input logic er, ew, input logic [31:0] ea, es,
                     input logic em);
    vec_t v;
    v.rst = rst; v.iren = iren; v.iaddr = ia; v.dren = dr; v.dwen = dw;
    v.daddr = da; v.dstore = ds; v.rs = rs; v.rl = rl;
    v.e_iwait = eiw; v.e_dwait = edw; v.e_iload = eil; v.e_dload = edl;
    v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es; v.e_merr = em;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, iren, input logic [31:0] ia,
                       input logic dr, dw, input logic [31:0] da, ds,
                       input logic [1:0] rs, input logic [31:0] rl);
    RST = rst; iREN = iren; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramstate = rs; ramload = rl;
  endtask

  logic exp_i [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    repeat (2) @(posedge CLK);

    //   rst ir iaddr  dr dw daddr  dstore  rs rl          | iw dw iload  dload  ren wen addr   store  merr
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,    0, 32'h0,        0, 0, 32'h0, 32'h0, 0, 0, 32'h0,   32'h0,    0);
    add(1, 1, 32'h0,  1, 0, 32'h0,   32'h0,    3, 32'h0,        1, 1, 32'h0, 32'h0, 0, 0, 32'h0,   32'h0,    0);
    // Instruction read with two BUSY cycles
    add(0, 1, 32'h40, 0, 0, 32'h0,   32'h0,    1, 32'h0,        1, 0, 32'h0, 32'h0, 0, 0, 32'h0,   32'h0,    0);
    add(0, 1, 32'h40, 0, 0, 32'h0,   32'h0,    1, 32'h0,        1, 0, 32'h0, 32'h0, 1, 0, 32'h40,  32'h0,    0);
    add(0, 1, 32'h40, 0, 0, 32'h0,   32'h0,    1, 32'h0,        1, 0, 32'h0, 32'h0, 1, 0, 32'h40,  32'h0,    0);
    add(0, 1, 32'h40, 0, 0, 32'h0,   32'h0,    2, 32'h8C010004, 0, 0, 32'h8C010004, 32'h0, 1, 0, 32'h40, 32'h0, 0);
    add(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,    2, 32'h1234,     0, 0, 32'h0, 32'h0, 0, 0, 32'h40,  32'h0,    0);
    // Simultaneous I and D write: D first
    add(0, 1, 32'h80, 0, 1, 32'h100, 32'hDEAD, 0, 32'h0,        1, 1, 32'h0, 32'h0, 0, 0, 32'h40,  32'h0,    0);
    add(0, 1, 32'h80, 0, 1, 32'h100, 32'hDEAD, 0, 32'h0,        1, 1, 32'h0, 32'h0, 0, 1, 32'h100, 32'hDEAD, 0);
    add(0, 1, 32'h80, 0, 1, 32'h100, 32'hDEAD, 2, 32'h5555,     1, 0, 32'h0, 32'h5555, 0, 1, 32'h100, 32'hDEAD, 0);
    add(0, 1, 32'h80, 0, 0, 32'h0,   32'h0,    0, 32'h0,        1, 0, 32'h0, 32'h0, 0, 0, 32'h100, 32'hDEAD, 0);
    add(0, 1, 32'h80, 0, 0, 32'h0,   32'h0,    1, 32'h0,        1, 0, 32'h0, 32'h0, 1, 0, 32'h80,  32'hDEAD, 0);
    add(0, 1, 32'h80, 0, 0, 32'h0,   32'h0,    2, 32'hCAFE,     0, 0, 32'hCAFE, 32'h0, 1, 0, 32'h80, 32'hDEAD, 0);
    // Data read aborted before ACCESS
    add(0, 0, 32'h0,  1, 0, 32'h200, 32'h77,   0, 32'h0,        0, 1, 32'h0, 32'h0, 0, 0, 32'h80,  32'hDEAD, 0);
    add(0, 0, 32'h0,  1, 0, 32'h200, 32'h77,   1, 32'h0,        0, 1, 32'h0, 32'h0, 1, 0, 32'h200, 32'h77,   0);
    add(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,    1, 32'h0,        0, 0, 32'h0, 32'h0, 1, 0, 32'h200, 32'h77,   0);
    add(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,    2, 32'h9,        0, 0, 32'h0, 32'h0, 0, 0, 32'h200, 32'h77,   0);
    // dREN and dWEN together is a write; ERROR completion
    add(0, 0, 32'h0,  1, 1, 32'h300, 32'hBEEF, 0, 32'h0,        0, 1, 32'h0, 32'h0, 0, 0, 32'h200, 32'h77,   0);
    add(0, 0, 32'h0,  1, 1, 32'h300, 32'hBEEF, 1, 32'h0,        0, 1, 32'h0, 32'h0, 0, 1, 32'h300, 32'hBEEF, 0);
    add(0, 0, 32'h0,  1, 1, 32'h300, 32'hBEEF, 3, 32'hE,        0, 0, 32'h0, 32'hE, 0, 1, 32'h300, 32'hBEEF, 1);
    // Instruction ERROR, then back-to-back regrant and abort
    add(0, 1, 32'h44, 0, 0, 32'h0,   32'h0,    0, 32'h0,        1, 0, 32'h0, 32'h0, 0, 0, 32'h300, 32'hBEEF, 0);
    add(0, 1, 32'h44, 0, 0, 32'h0,   32'h0,    1, 32'h0,        1, 0, 32'h0, 32'h0, 1, 0, 32'h44,  32'hBEEF, 0);
    add(0, 1, 32'h44, 0, 0, 32'h0,   32'h0,    3, 32'hBAD,      0, 0, 32'hBAD, 32'h0, 1, 0, 32'h44, 32'hBEEF, 1);
    add(0, 1, 32'h44, 0, 0, 32'h0,   32'h0,    3, 32'h0,        1, 0, 32'h0, 32'h0, 0, 0, 32'h44,  32'hBEEF, 0);
    add(0, 1, 32'h44, 0, 0, 32'h0,   32'h0,    1, 32'h0,        1, 0, 32'h0, 32'h0, 1, 0, 32'h44,  32'hBEEF, 0);
    add(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,    0, 32'h0,        0, 0, 32'h0, 32'h0, 1, 0, 32'h44,  32'hBEEF, 0);
    // Reset in the middle of a data write
    add(0, 0, 32'h0,  0, 1, 32'h400, 32'h11,   0, 32'h0,        0, 1, 32'h0, 32'h0, 0, 0, 32'h44,  32'hBEEF, 0);
    add(0, 0, 32'h0,  0, 1, 32'h400, 32'h11,   1, 32'h0,        0, 1, 32'h0, 32'h0, 0, 1, 32'h400, 32'h11,   0);
    add(1, 0, 32'h0,  0, 1, 32'h400, 32'h11,   3, 32'h0,        0, 1, 32'h0, 32'h0, 0, 1, 32'h400, 32'h11,   0);
    add(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,    2, 32'h0,        0, 0, 32'h0, 32'h0, 0, 0, 32'h0,   32'h0,    0);

    for (int k = 0; k < vq.size(); k++) begin
      @(posedge CLK);
      #1;
      drive(vq[k].rst, vq[k].iren, vq[k].iaddr, vq[k].dren, vq[k].dwen,
            vq[k].daddr, vq[k].dstore, vq[k].rs, vq[k].rl);
      @(negedge CLK);
      chk($sformatf("v%0d iwait", k),    {31'b0, iwait},  {31'b0, vq[k].e_iwait});
      chk($sformatf("v%0d dwait", k),    {31'b0, dwait},  {31'b0, vq[k].e_dwait});
      chk($sformatf("v%0d iload", k),    iload,           vq[k].e_iload);
      chk($sformatf("v%0d dload", k),    dload,           vq[k].e_dload);
      chk($sformatf("v%0d ramREN", k),   {31'b0, ramREN}, {31'b0, vq[k].e_ren});
      chk($sformatf("v%0d ramWEN", k),   {31'b0, ramWEN}, {31'b0, vq[k].e_wen});
      chk($sformatf("v%0d ramaddr", k),  ramaddr,         vq[k].e_addr);
      chk($sformatf("v%0d ramstore", k), ramstore,        vq[k].e_store);
      chk($sformatf("v%0d merr", k),     {31'b0, merr},   {31'b0, vq[k].e_merr});
    end

    // Starvation bound: I waits through exactly four D completions, twice.
    begin
      int n = 0;
      int last = -1;
      for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
        @(posedge CLK);
        #1;
        drive(1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 32'h99);
        @(negedge CLK);
        if (!iwait || !dwait) begin
          chk($sformatf("starve grant%0d is_i", n), {31'b0, !iwait}, {31'b0, exp_i[n]});
          chk($sformatf("starve grant%0d addr", n), ramaddr, exp_i[n] ? 32'h500 : 32'h600);
          if (last >= 0)
            chk($sformatf("starve grant%0d spacing", n), cyc - last, 32'd2);
          last = cyc;
          n++;
        end
      end
      chk("starve completions", n, 32'd10);
    end

    @(posedge CLK);
    #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    repeat (2) @(posedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
